pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch sequencer that owns the program counter and drives the instruction-memory port for the RV32 core front end. It issues one fetch at a time over a request/grant/response handshake, advances the PC by 4, and applies branch/jump redirects from execute. It holds a fetched instruction while decode is stalled and discards in-flight responses made stale by a redirect.

## Interface
- D_WIDTH, 32: address/PC width
- RESET_PC, 32'h0000_0000: PC loaded at reset
---
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- PCsrc  in  1  redirect request (taken branch/jump), single-cycle pulse
- branch_PC  in  D_WIDTH  redirect target, valid when PCsrc=1
- stall  in  1  decode not ready; holds if_* outputs
- imem_req  out  1  fetch request
- imem_addr  out  D_WIDTH  fetch address (= pc), valid with imem_req
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid, at most one per granted request, ≥1 cycle after gnt
- imem_rdata  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_pc  out  D_WIDTH  address of if_instr
- if_instr  out  32  fetched instruction
- misalign_err  out  1  sticky: a redirect target had bits [1:0] ≠ 0

## Operation
- Registers: pc, fetch_pc, kill, state ∈ {BOOT, REQ, WAIT, HOLD}, if_* output registers, misalign_err.
- Priority: rst=0 > PCsrc > normal sequencing.
- BOOT: imem_req=0; next state REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_gnt: fetch_pc←pc, pc←pc+4 (mod 2^D_WIDTH; wraps silently), next WAIT. Without gnt, remain in REQ; imem_addr stays stable.
- WAIT: imem_req=0. On imem_rvalid:
  - kill=0: if_instr←imem_rdata, if_pc←fetch_pc, if_valid←1, next HOLD.
  - kill=1: drop data, kill←0, next REQ.
- HOLD: if_valid=1 and if_* stable while stall=1. When stall=0, the instruction is consumed that cycle: if_valid←0, next REQ.
- Redirect (PCsrc=1), in any state:
  - pc←{branch_PC[D_WIDTH-1:2],2'b00}; misalign_err←1 if branch_PC[1:0]≠0.
  - if_valid←0.
  - BOOT/REQ without gnt/HOLD: next REQ.
  - REQ with gnt same cycle: the granted fetch is stale, so kill←1, next WAIT, and pc is not incremented.
  - WAIT without rvalid: kill←1, stay WAIT.
  - WAIT with rvalid same cycle: drop data, next REQ.
- Only one fetch outstanding; imem_req is never asserted in WAIT or HOLD.

## Timing
- While rst=0 at a clock edge: pc=RESET_PC, state=BOOT, kill=0, if_valid=0, if_pc=0, if_instr=0, misalign_err=0. imem_req=0 (BOOT).
- First imem_req occurs in the first cycle after rst rises (BOOT→REQ takes one cycle).
- With a zero-wait memory (gnt in REQ cycle t, rvalid at t+1), if_valid is high at t+2. If stall=0, next imem_req is at t+3. Throughput: 1 instruction / 3 cycles.
- Redirect at cycle t: if_valid=0 from t+1. The first fetch of the target is issued at t+1 (or after the stale response arrives).
- Reset asserted mid-fetch returns to BOOT. A response to the abandoned request arriving in BOOT/REQ is ignored (rvalid is only sampled in WAIT).
- imem_req/imem_addr are decoded from registered state/pc only; no combinational path from imem_gnt/imem_rvalid to imem_req.

## Test plan
- Reset/boot: RESET_PC=0x100, release rst, zero-wait memory -> imem_req at cycle 1 with addr 0x100. Sequential fetches 0x100, 0x104, 0x108 give if_pc matching and if_valid every 3rd cycle.
- Stall hold: assert stall for 5 cycles while if_valid=1 with instr 0x00500093 -> if_valid, if_pc and if_instr unchanged, no imem_req. Release -> imem_req next cycle at pc+4.
- Redirect during WAIT: 3-cycle memory latency, PCsrc with branch_PC=0x200 one cycle after gnt -> stale rdata dropped (if_valid stays 0), next imem_addr=0x200, then if_pc=0x200.
- Redirect coincident with gnt and with rvalid: each case -> old data never appears on if_*, next fetch address = target.
- Misaligned target 0x203 -> misalign_err=1 and sticky until reset, next imem_addr=0x200.
- Wrap: pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000. Reset in HOLD -> if_valid=0 next cycle and the sequence restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer for the RV32 front end: owns the PC, runs one outstanding
// request/grant/response fetch at a time, and applies execute redirects.
module pc_fetch_ctrl #(
  parameter int                   D_WIDTH  = 32,
  parameter logic [D_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCsrc,
  input  logic [D_WIDTH-1:0] branch_PC,
  input  logic               stall,
  output logic               imem_req,
  output logic [D_WIDTH-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic               if_valid,
  output logic [D_WIDTH-1:0] if_pc,
  output logic [31:0]        if_instr,
  output logic               misalign_err,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t               r_state;
  logic [D_WIDTH-1:0]   r_pc;
  logic [D_WIDTH-1:0]   r_fetch_pc;
  logic                 r_kill;
  logic                 r_if_valid;
  logic [D_WIDTH-1:0]   r_if_pc;
  logic [31:0]          r_if_instr;
  logic                 r_misalign;

  state_t               w_state_nxt;
  logic [D_WIDTH-1:0]   w_pc_nxt;
  logic [D_WIDTH-1:0]   w_fetch_pc_nxt;
  logic                 w_kill_nxt;
  logic                 w_if_valid_nxt;
  logic [D_WIDTH-1:0]   w_if_pc_nxt;
  logic [31:0]          w_if_instr_nxt;
  logic                 w_misalign_nxt;
  logic [D_WIDTH-1:0]   w_target;

  // Handshake: a fetch is accepted on a cycle where imem_req && imem_gnt;
  // exactly one imem_rvalid follows it, no earlier than the next cycle.
  // imem_req comes from registered state only, so it never depends on gnt/rvalid.
  assign imem_req     = (r_state == ST_REQ);
  assign imem_addr    = r_pc;
  assign if_valid     = r_if_valid;
  assign if_pc        = r_if_pc;
  assign if_instr     = r_if_instr;
  assign misalign_err = r_misalign;
  assign dbg_state    = r_state;

  assign w_target = {branch_PC[D_WIDTH-1:2], 2'b00};

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_fetch_pc_nxt = r_fetch_pc;
    w_kill_nxt     = r_kill;
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    w_misalign_nxt = r_misalign;

    if (PCsrc) begin
      w_pc_nxt       = w_target;
      w_misalign_nxt = r_misalign | (branch_PC[1:0] != 2'b00);
      w_if_valid_nxt = 1'b0;
      w_kill_nxt     = 1'b0;
      w_state_nxt    = ST_REQ;
      case (r_state)
        // A grant in the redirect cycle launches a fetch that is already stale.
        ST_REQ: begin
          if (imem_gnt) begin
            w_kill_nxt  = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!imem_rvalid) begin
            w_kill_nxt  = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
        default: ;
      endcase
    end else begin
      case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (imem_gnt) begin
            w_fetch_pc_nxt = r_pc;
            w_pc_nxt       = r_pc + D_WIDTH'(4);
            w_state_nxt    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (r_kill) begin
              w_kill_nxt  = 1'b0;
              w_state_nxt = ST_REQ;
            end else begin
              w_if_instr_nxt = imem_rdata;
              w_if_pc_nxt    = r_fetch_pc;
              w_if_valid_nxt = 1'b1;
              w_state_nxt    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            w_if_valid_nxt = 1'b0;
            w_state_nxt    = ST_REQ;
          end
        end
        default: begin
          w_state_nxt = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_fetch_pc <= '0;
      r_kill     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized traffic checked
// against a program-order model (expected fetch/delivery address streams).
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] branch_PC = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_err;
  logic [1:0]  dbg_state;

  pc_fetch_ctrl #(.D_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .PCsrc(PCsrc), .branch_PC(branch_PC), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr), .misalign_err(misalign_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory / traffic knobs
  int gnt_pct = 100, lat_lo = 1, lat_hi = 1, stall_pct = 0;
  bit force_rv = 1'b0;

  // memory model state
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;

  // program-order model
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] exp_del   = RESET_PC;
  logic        exp_mis   = 1'b0;

  // snapshot of DUT outputs for the current cycle
  logic        s_req = 1'b0, s_valid = 1'b0, s_mis = 1'b0;
  logic [31:0] s_addr = '0, s_pc = '0, s_instr = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a == 32'h0000_010C) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: choose memory/decode inputs from the current outputs,
  // advance the clock, update the model, then compare the new outputs.
  task automatic cyc(input logic pc_i = 1'b0, input logic [31:0] bp_i = 32'h0);
    logic        g, rv, st;
    logic [31:0] rd, tgt;
    logic        n_req, n_valid, n_mis;
    logic [31:0] n_addr, n_pc, n_instr;
    g  = s_req && ($urandom_range(99, 0) < gnt_pct);
    rv = pending && (cnt == 0);
    rd = instr_of(pend_addr);
    if (force_rv) begin
      rv = 1'b1;
      rd = 32'hDEAD_BEEF;
    end
    st = ($urandom_range(99, 0) < stall_pct);
    PCsrc       = pc_i;
    branch_PC   = bp_i;
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rv ? rd : $urandom;
    stall       = st;
    @(posedge clk);
    #1;
    tgt = {bp_i[31:2], 2'b00};
    if (!rst) begin
      pending   = 1'b0;
      exp_fetch = RESET_PC;
      exp_del   = RESET_PC;
      exp_mis   = 1'b0;
    end else begin
      if (pending && rv) pending = 1'b0;
      else if (pending && cnt > 0) cnt--;
      if (g) begin
        pending   = 1'b1;
        pend_addr = s_addr;
        cnt       = int'($urandom_range(lat_hi, lat_lo)) - 1;
      end
      if (pc_i) begin
        exp_fetch = tgt;
        exp_del   = tgt;
        if (bp_i[1:0] != 2'b00) exp_mis = 1'b1;
      end else if (g) begin
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    n_req = imem_req; n_addr = imem_addr; n_valid = if_valid;
    n_pc = if_pc; n_instr = if_instr; n_mis = misalign_err;
    if (!rst) begin
      check("rst_req", n_req, 0);
      check("rst_valid", n_valid, 0);
      check("rst_if_pc", n_pc, 0);
      check("rst_if_instr", n_instr, 0);
      check("rst_misalign", n_mis, 0);
      check("rst_state_boot", dbg_state, 0);
    end else begin
      if (pc_i) check("redirect_clears_valid", n_valid, 0);
      if (s_valid && st && !pc_i) begin
        check("hold_valid", n_valid, 1);
        check("hold_pc", n_pc, s_pc);
        check("hold_instr", n_instr, s_instr);
      end
      if (s_valid && !st && !pc_i) check("consume_valid", n_valid, 0);
      if (n_valid && !s_valid) begin
        check("deliver_pc", n_pc, exp_del);
        check("deliver_instr", n_instr, instr_of(exp_del));
        exp_del = exp_del + 32'd4;
      end
      check("misalign_sticky", n_mis, exp_mis);
      if (pending) check("no_req_outstanding", n_req, 0);
      if (n_req) check("fetch_addr", n_addr, exp_fetch);
    end
    s_req = n_req; s_addr = n_addr; s_valid = n_valid;
    s_pc = n_pc; s_instr = n_instr; s_mis = n_mis;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 60 && !s_req; i++) cyc();
    check("wait_req_timeout", s_req, 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60 && !s_valid; i++) cyc();
    check("wait_valid_timeout", s_valid, 1);
  endtask

  initial begin
    logic [31:0] held_pc, held_instr;
    logic [31:0] bp;

    // reset and boot
    rst = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    check("first_req", s_req, 1);
    check("first_addr", s_addr, RESET_PC);

    // zero-wait memory: one instruction every third cycle
    for (int k = 1; k <= 9; k++) begin
      cyc();
      check("zw_req_pattern", s_req, (k % 3) == 0);
      check("zw_valid_pattern", s_valid, (k % 3) == 2);
      if ((k % 3) == 2) check("zw_if_pc", s_pc, RESET_PC + 32'(4 * ((k - 2) / 3)));
    end

    // stall hold for 5 cycles on 0x10C
    stall_pct = 100;
    wait_valid();
    held_pc = s_pc; held_instr = s_instr;
    check("stall_instr", s_instr, 32'h0050_0093);
    repeat (5) begin
      cyc();
      check("stall_no_req", s_req, 0);
      check("stall_pc", s_pc, held_pc);
      check("stall_instr_stable", s_instr, held_instr);
    end
    stall_pct = 0;
    cyc();
    check("release_req", s_req, 1);
    check("release_addr", s_addr, held_pc + 32'd4);

    // redirect during WAIT with 3-cycle latency
    lat_lo = 3; lat_hi = 3;
    wait_req();
    cyc();
    cyc(1'b1, 32'h0000_0200);
    wait_valid();
    check("redir_wait_pc", s_pc, 32'h0000_0200);

    // redirect coincident with grant
    wait_req();
    cyc(1'b1, 32'h0000_0300);
    wait_valid();
    check("redir_gnt_pc", s_pc, 32'h0000_0300);

    // redirect coincident with rvalid
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 60 && !(pending && cnt == 0); i++) cyc();
    check("rv_window_timeout", pending && cnt == 0, 1);
    cyc(1'b1, 32'h0000_0400);
    wait_valid();
    check("redir_rv_pc", s_pc, 32'h0000_0400);

    // misaligned target
    lat_lo = 1; lat_hi = 1;
    cyc(1'b1, 32'h0000_0203);
    check("misalign_set", s_mis, 1);
    wait_valid();
    check("misalign_pc", s_pc, 32'h0000_0200);

    // PC wrap
    cyc(1'b1, 32'hFFFF_FFFC);
    wait_valid();
    check("wrap_pc", s_pc, 32'hFFFF_FFFC);
    cyc();
    wait_req();
    check("wrap_addr", s_addr, 32'h0000_0000);
    check("misalign_still_set", s_mis, 1);

    // reset while holding an instruction
    stall_pct = 100;
    wait_valid();
    rst = 1'b0;
    cyc();
    check("rst_hold_valid", s_valid, 0);
    rst = 1'b1;
    stall_pct = 0;
    cyc();
    check("restart_addr", s_addr, RESET_PC);

    // abandoned response arriving in BOOT/REQ is ignored
    lat_lo = 4; lat_hi = 4;
    wait_req();
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    gnt_pct = 0; force_rv = 1'b1;
    cyc();
    cyc();
    check("abandon_no_valid", s_valid, 0);
    force_rv = 1'b0; gnt_pct = 100; lat_lo = 1;
    wait_valid();
    check("abandon_restart_pc", s_pc, RESET_PC);

    // randomized traffic
    gnt_pct = 70; lat_lo = 1; lat_hi = 4; stall_pct = 40;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99, 0) < 6) begin
        bp = $urandom;
        if ($urandom_range(9, 0) != 0) bp[1:0] = 2'b00;
        cyc(1'b1, bp);
      end else begin
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
